// File: rtl/xglyph_row_writer.sv
// Register-window character queue that streams glyph rows to video memory,
// one ROM-looked-up pixel row per valid/ready beat.
module xglyph_row_writer #(
   parameter  int ADDR_W     = 5,
   parameter  int CODE_W     = 5,
   parameter  int ROW_W      = 16,
   parameter  int ROWS       = 5,
   parameter  int FIFO_DEPTH = 4,
   localparam int ROW_BITS   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel,
   input  logic [1:0]          reg_addr,
   input  logic [7:0]          data_in,
   output logic                fifo_full,
   output logic                busy,
   output logic                ovf,
   output logic [CODE_W-1:0]   rom_code,
   output logic [ROW_BITS-1:0] rom_row,
   input  logic [ROW_W-1:0]    rom_bits,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [ROW_BITS-1:0] wr_row,
   output logic [ROW_W-1:0]    wr_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ADDR_W + CODE_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [PTR_W:0]      r_count;
   logic [ADDR_W-1:0]   r_cursor;
   logic                r_autoinc;
   logic                r_ovf;
   logic [ADDR_W-1:0]   r_cur_addr;
   logic [CODE_W-1:0]   r_cur_code;
   logic [ROW_BITS-1:0] r_row;
   logic                r_wr_valid;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [ROW_BITS-1:0] r_wr_row;
   logic [ROW_W-1:0]    r_wr_data;

   logic                w_full;
   logic                w_empty;
   logic                w_wr_cursor;
   logic                w_wr_push;
   logic                w_wr_ctrl;
   logic                w_push;
   logic                w_drop;
   logic                w_pop;
   logic                w_fetch;
   logic                w_accept;
   logic                w_last;
   logic [ENT_W-1:0]    w_head;
   logic                w_unused_ok;

   // Full uses start-of-cycle occupancy, so a same-edge pop never rescues a push.
   assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_empty     = (r_count == (PTR_W+1)'(0));
   assign w_wr_cursor = sel && (reg_addr == 2'd0);
   assign w_wr_push   = sel && (reg_addr == 2'd1);
   assign w_wr_ctrl   = sel && (reg_addr == 2'd2);
   assign w_push      = w_wr_push && !w_full;
   assign w_drop      = w_wr_push && w_full;
   assign w_last      = (r_row == ROW_BITS'(ROWS - 1));
   assign w_head      = r_fifo[r_rptr];
   assign w_unused_ok = &{1'b0, data_in};

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_fetch     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            w_fetch     = 1'b1;
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            if (wr_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = w_last ? S_IDLE : S_FETCH;
            end else begin
               w_state_nxt = S_SEND;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Command FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= {r_cursor, data_in[CODE_W-1:0]};
      end
   end

   // Command FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= {PTR_W{1'b0}};
         r_rptr  <= {PTR_W{1'b0}};
         r_count <= {(PTR_W+1){1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Register window: cursor, auto-increment and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cursor  <= {ADDR_W{1'b0}};
         r_autoinc <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_wr_cursor) begin
            r_cursor <= data_in[ADDR_W-1:0];
         end else if (w_push && r_autoinc) begin
            r_cursor <= r_cursor + ADDR_W'(1);
         end
         if (w_wr_ctrl) begin
            r_autoinc <= data_in[0];
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_wr_ctrl && data_in[1]) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Current character, row counter and registered write beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur_addr <= {ADDR_W{1'b0}};
         r_cur_code <= {CODE_W{1'b0}};
         r_row      <= {ROW_BITS{1'b0}};
         r_wr_valid <= 1'b0;
         r_wr_addr  <= {ADDR_W{1'b0}};
         r_wr_row   <= {ROW_BITS{1'b0}};
         r_wr_data  <= {ROW_W{1'b0}};
      end else begin
         if (w_pop) begin
            r_cur_addr <= w_head[ENT_W-1:CODE_W];
            r_cur_code <= w_head[CODE_W-1:0];
            r_row      <= {ROW_BITS{1'b0}};
         end else if (w_accept && !w_last) begin
            r_row <= r_row + ROW_BITS'(1);
         end
         if (w_fetch) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_cur_addr;
            r_wr_row   <= r_row;
            r_wr_data  <= rom_bits;
         end else if (w_accept) begin
            r_wr_valid <= 1'b0;
         end
      end
   end

   // ROM selects come straight from the current-character registers, which only move on pop/advance.
   assign rom_code  = r_cur_code;
   assign rom_row   = r_row;
   assign fifo_full = w_full;
   assign busy      = (r_state != S_IDLE) || !w_empty;
   assign ovf       = r_ovf;
   assign wr_valid  = r_wr_valid;
   assign wr_addr   = r_wr_addr;
   assign wr_row    = r_wr_row;
   assign wr_data   = r_wr_data;

endmodule
